// File: rtl/send_arbiter_pkg.sv
// Shared types and constants for the word-atomic send arbiter.
package send_arbiter_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  // Bytes per atomic word; the serializer marks every WORD_LEN-th byte
  localparam int WORD_LEN = 4;

  // Default filler behaviour when a granted source stalls mid-word
  localparam int         DEF_PAD_TIMEOUT = 255;
  localparam logic [7:0] DEF_PAD_BYTE    = 8'h00;

endpackage

// File: rtl/send_arbiter_if.sv
// Bundle of source, serializer and status signals around the arbiter.
// Handshake: a source byte moves on a rising clk edge where req_valid[i]
// and req_ready[i] are both high; valid must not wait for ready, and ready
// depends only on arbiter state, never on valid. transmit is a one-cycle
// start strobe to the serializer with tx_byte valid in that cycle.
interface send_arbiter_if
  import send_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 transmit;
  logic [7:0]           tx_byte;
  logic                 is_transmitting;
  logic [2:0]           grant_id;
  logic                 word_active;
  logic [15:0]          pad_count;
  state_t               dbg_state;
  logic [1:0]           dbg_byte_cnt;

  // Sources and serializer side
  modport master (
    output req_valid, req_data, is_transmitting,
    input  req_ready, transmit, tx_byte, grant_id, word_active, pad_count,
           dbg_state, dbg_byte_cnt
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, is_transmitting,
    output req_ready, transmit, tx_byte, grant_id, word_active, pad_count,
           dbg_state, dbg_byte_cnt
  );

endinterface

// File: rtl/send_arbiter_rr_pick.sv
// Round-robin pick: first valid index after i_last, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [2:0]         i_last,
  output logic [2:0]         o_winner,
  output logic               o_found
);

  int w_dist;
  int w_best;

  // Choose the valid source with the smallest distance past i_last
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_best   = NUM_REQ;
    w_dist   = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_valid[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = 3'(j);
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/send_arbiter.sv
// Arbitrates byte sources onto one serializer in atomic 4-byte words so the
// serializer's every-4th-byte sync marker stays on word boundaries.
module send_arbiter
  import send_arbiter_pkg::*;
#(
  parameter int         NUM_REQ     = 3,
  parameter int         PAD_TIMEOUT = DEF_PAD_TIMEOUT,
  parameter logic [7:0] PAD_BYTE    = DEF_PAD_BYTE
) (
  input logic           clk,
  input logic           rst,
  send_arbiter_if.slave bus
);

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_grant;
  logic [2:0]           r_last;
  logic [1:0]           r_byte_cnt;
  logic [7:0]           r_stall_cnt;
  logic                 r_transmit;
  logic [7:0]           r_tx_byte;
  logic [15:0]          r_pad_count;
  logic [2:0]           w_winner;
  logic                 w_found;
  logic                 w_sel_valid;
  logic [7:0]           w_sel_data;
  logic [NUM_REQ-1:0]   w_grant_onehot;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_issue_data;
  logic                 w_issue_pad;
  logic                 w_stall_done;
  logic                 w_word_last;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_valid  (bus.req_valid),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  // Decode the owning source's valid/data and its one-hot ready position
  always_comb begin
    w_grant_onehot = '0;
    w_sel_valid    = 1'b0;
    w_sel_data     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant == 3'(j)) begin
        w_grant_onehot[j] = 1'b1;
        w_sel_valid       = bus.req_valid[j];
        w_sel_data        = bus.req_data[8*j +: 8];
      end
    end
  end

  // This stall cycle is the PAD_TIMEOUT-th in a row, so a pad goes out now
  assign w_stall_done = (r_stall_cnt == 8'(PAD_TIMEOUT - 1));
  assign w_word_last  = (r_byte_cnt == 2'(WORD_LEN - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ARB;
    else     r_state <= w_next_state;
  end

  // Next state, ready and byte-issue decisions
  always_comb begin
    w_next_state = r_state;
    w_ready      = '0;
    w_issue_data = 1'b0;
    w_issue_pad  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = w_grant_onehot;
        if (w_sel_valid) begin
          w_issue_data = 1'b1;
          w_next_state = ST_WAIT_HI;
        end else if (w_stall_done) begin
          w_issue_pad  = 1'b1;
          w_next_state = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (bus.is_transmitting) w_next_state = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!bus.is_transmitting) w_next_state = w_word_last ? ST_ARB : ST_LOAD;
      end
      default: w_next_state = ST_ARB;
    endcase
  end

  // Grant, counters and the registered serializer strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant     <= '0;
      r_last      <= 3'(NUM_REQ - 1);
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
      r_transmit  <= 1'b0;
      r_tx_byte   <= '0;
      r_pad_count <= '0;
    end else begin
      r_transmit <= w_issue_data | w_issue_pad;
      if (w_issue_data) r_tx_byte <= w_sel_data;
      if (w_issue_pad)  r_tx_byte <= PAD_BYTE;
      if (w_issue_pad && (r_pad_count != 16'hFFFF)) r_pad_count <= r_pad_count + 16'd1;
      if ((r_state == ST_ARB) && w_found) begin
        r_grant     <= w_winner;
        r_last      <= w_winner;
        r_byte_cnt  <= '0;
        r_stall_cnt <= '0;
      end
      if (r_state == ST_LOAD) begin
        if (w_issue_data || w_issue_pad) r_stall_cnt <= '0;
        else                             r_stall_cnt <= r_stall_cnt + 8'd1;
      end
      if ((r_state == ST_WAIT_LO) && !bus.is_transmitting) r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.transmit     = r_transmit;
  assign bus.tx_byte      = r_tx_byte;
  assign bus.grant_id     = r_grant;
  assign bus.word_active  = (r_state != ST_ARB);
  assign bus.pad_count    = r_pad_count;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: queue-backed byte sources, an 8-cycle serializer
// model with a mod-4 sync counter, and word-level expectations.
module tb_send_arbiter;
  import send_arbiter_pkg::*;

  localparam int         NR = 3;
  localparam int         PT = 255;
  localparam logic [7:0] PB = 8'h00;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic [2:0] gid;
    logic       sync;
  } tx_rec_t;

  typedef struct {
    logic [7:0] b;
    logic [2:0] gid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         viol_cnt = 0;
  logic       prev_tx = 1'b0;
  logic [3:0] ser_busy;
  logic [1:0] ser_cnt;
  logic       en [NR];
  logic [7:0] src_q [NR][$];
  int         xfer_cnt [NR];
  tx_rec_t    got_q [$];
  exp_t       exp_q [$];

  send_arbiter_if #(.NUM_REQ(NR)) bus ();

  send_arbiter #(.NUM_REQ(NR), .PAD_TIMEOUT(PT), .PAD_BYTE(PB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial forever #5 clk = ~clk;

  // Serializer model: busy 8 cycles per byte, sync on every 4th byte
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_busy <= 4'd0;
      ser_cnt  <= 2'd0;
    end else if (bus.transmit) begin
      ser_busy <= 4'd8;
      ser_cnt  <= ser_cnt + 2'd1;
    end else if (ser_busy != 4'd0) begin
      ser_busy <= ser_busy - 4'd1;
    end
  end
  assign bus.is_transmitting = (ser_busy != 4'd0);

  // Protocol watch: no transmit while busy and no back-to-back strobes
  always @(negedge clk) begin
    if (rst) prev_tx <= 1'b0;
    else begin
      if (bus.transmit && (bus.is_transmitting || prev_tx)) viol_cnt <= viol_cnt + 1;
      prev_tx <= bus.transmit;
    end
  end

  // One cycle: observe outputs, drive sources, retire accepted bytes
  task automatic step();
    logic [NR-1:0]   v;
    logic [8*NR-1:0] d;
    logic [7:0]      dummy;
    @(negedge clk);
    cyc++;
    if (bus.transmit)
      got_q.push_back('{cyc: cyc, b: bus.tx_byte, gid: bus.grant_id, sync: (ser_cnt == 2'd3)});
    v = '0;
    d = '0;
    for (int j = 0; j < NR; j++) begin
      if (en[j] && (src_q[j].size() > 0)) begin
        v[j]         = 1'b1;
        d[8*j +: 8] = src_q[j][0];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    for (int j = 0; j < NR; j++) begin
      if (v[j] && bus.req_ready[j] && !rst) begin
        dummy = src_q[j].pop_front();
        xfer_cnt[j]++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int j = 0; j < NR; j++) begin
      src_q[j].delete();
      en[j]       = 1'b1;
      xfer_cnt[j] = 0;
    end
    repeat (3) step();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic wait_tx(input int n, input int bound, input string name);
    int guard = 0;
    while ((got_q.size() < n) && (guard < bound)) begin
      step();
      guard++;
    end
    n_checks++;
    if (got_q.size() < n) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d transmits, expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks += 7;
    if (bus.transmit !== 1'b0)   begin n_errors++; $display("FAIL rst_transmit: got %b expected 0", bus.transmit); end
    if (bus.tx_byte !== 8'h00)   begin n_errors++; $display("FAIL rst_tx_byte: got %h expected 00", bus.tx_byte); end
    if (bus.req_ready !== '0)    begin n_errors++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready); end
    if (bus.grant_id !== 3'd0)   begin n_errors++; $display("FAIL rst_grant: got %0d expected 0", bus.grant_id); end
    if (bus.word_active !== 1'b0) begin n_errors++; $display("FAIL rst_word_active: got %b expected 0", bus.word_active); end
    if (bus.pad_count !== 16'd0) begin n_errors++; $display("FAIL rst_pad_count: got %0d expected 0", bus.pad_count); end
    if (bus.dbg_state !== ST_ARB) begin n_errors++; $display("FAIL rst_state: got %0d expected %0d", bus.dbg_state, ST_ARB); end
  endtask

  task automatic test_single_source();
    int c0;
    do_reset();
    for (int k = 0; k < 4; k++) src_q[1].push_back(8'hA0 + 8'(k));
    c0 = cyc + 1;
    wait_tx(4, 200, "single");
    if (got_q.size() == 4) begin
      n_checks += 2;
      if (got_q[0].cyc !== c0 + 2) begin n_errors++; $display("FAIL single_latency: got cycle %0d expected %0d", got_q[0].cyc, c0 + 2); end
      if (bus.word_active !== 1'b1) begin n_errors++; $display("FAIL single_active: got %b expected 1", bus.word_active); end
      for (int i = 0; i < 4; i++) begin
        n_checks += 3;
        if (got_q[i].b !== 8'hA0 + 8'(i)) begin n_errors++; $display("FAIL single_byte%0d: got %h expected %h", i, got_q[i].b, 8'hA0 + 8'(i)); end
        if (got_q[i].gid !== 3'd1) begin n_errors++; $display("FAIL single_gid%0d: got %0d expected 1", i, got_q[i].gid); end
        if (got_q[i].sync !== (i == 3)) begin n_errors++; $display("FAIL single_sync%0d: got %b expected %b", i, got_q[i].sync, (i == 3)); end
        if (i > 0) begin
          n_checks++;
          if (got_q[i].cyc - got_q[i-1].cyc !== 11) begin n_errors++; $display("FAIL single_gap%0d: got %0d expected 11", i, got_q[i].cyc - got_q[i-1].cyc); end
        end
      end
    end
    repeat (12) step();
    n_checks += 2;
    if (bus.word_active !== 1'b0) begin n_errors++; $display("FAIL single_idle: got %b expected 0", bus.word_active); end
    if (xfer_cnt[1] !== 4) begin n_errors++; $display("FAIL single_xfers: got %0d expected 4", xfer_cnt[1]); end
  endtask

  task automatic test_round_robin();
    logic [7:0] mq [NR][$];
    int last, pick, total, found;
    do_reset();
    exp_q.delete();
    total = 0;
    for (int j = 0; j < NR; j++) begin
      int nw = (j == 0) ? 2 : $urandom_range(1, 2);
      for (int k = 0; k < 4 * nw; k++) src_q[j].push_back(8'($urandom_range(0, 255)));
      mq[j] = src_q[j];
      total += 4 * nw;
    end
    // Word-level model: each word goes to the next source after the last winner that still has data
    last = NR - 1;
    forever begin
      found = 0;
      pick  = 0;
      for (int k = 1; k <= NR; k++) begin
        if ((found == 0) && (mq[(last + k) % NR].size() > 0)) begin
          found = 1;
          pick  = (last + k) % NR;
        end
      end
      if (found == 0) break;
      for (int k = 0; k < 4; k++) exp_q.push_back('{b: mq[pick].pop_front(), gid: 3'(pick)});
      last = pick;
    end
    wait_tx(total, 13 * total + 60, "rr");
    if (got_q.size() == total) begin
      for (int i = 0; i < total; i++) begin
        n_checks += 2;
        if (got_q[i].b !== exp_q[i].b) begin n_errors++; $display("FAIL rr_byte%0d: got %h expected %h", i, got_q[i].b, exp_q[i].b); end
        if (got_q[i].gid !== exp_q[i].gid) begin n_errors++; $display("FAIL rr_gid%0d: got %0d expected %0d", i, got_q[i].gid, exp_q[i].gid); end
      end
    end
  endtask

  task automatic test_pad();
    logic [7:0] b [3];
    logic [7:0] e [4];
    int dropped, drop_cyc, guard;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      b[k] = 8'($urandom_range(1, 255));
      src_q[0].push_back(b[k]);
    end
    e[0] = b[0]; e[1] = b[1]; e[2] = PB; e[3] = b[2];
    dropped = 0;
    drop_cyc = 0;
    guard = 0;
    while ((got_q.size() < 4) && (guard < 1200)) begin
      step();
      guard++;
      if ((dropped == 0) && (xfer_cnt[0] == 2)) begin
        en[0] = 1'b0;
        dropped = 1;
        drop_cyc = cyc;
      end
      if ((dropped == 1) && (cyc - drop_cyc >= 300)) begin
        en[0] = 1'b1;
        dropped = 2;
      end
    end
    n_checks++;
    if (got_q.size() < 4) begin n_errors++; $display("FAIL pad_timeout: got %0d transmits, expected 4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks += 2;
        if (got_q[i].b !== e[i]) begin n_errors++; $display("FAIL pad_byte%0d: got %h expected %h", i, got_q[i].b, e[i]); end
        if (got_q[i].gid !== 3'd0) begin n_errors++; $display("FAIL pad_gid%0d: got %0d expected 0", i, got_q[i].gid); end
      end
      n_checks += 2;
      if (got_q[2].cyc - got_q[1].cyc !== 10 + PT) begin n_errors++; $display("FAIL pad_gap: got %0d expected %0d", got_q[2].cyc - got_q[1].cyc, 10 + PT); end
      if (got_q[3].sync !== 1'b1) begin n_errors++; $display("FAIL pad_sync: got %b expected 1", got_q[3].sync); end
    end
    n_checks += 2;
    if (bus.pad_count !== 16'd1) begin n_errors++; $display("FAIL pad_count: got %0d expected 1", bus.pad_count); end
    if (xfer_cnt[0] !== 3) begin n_errors++; $display("FAIL pad_xfers: got %0d expected 3", xfer_cnt[0]); end
  endtask

  task automatic test_skip_idle();
    logic [7:0] b [8];
    int armed, guard;
    do_reset();
    en[2] = 1'b0;
    for (int k = 0; k < 8; k++) b[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(b[k]);
      src_q[2].push_back(b[k + 4]);
    end
    armed = 0;
    guard = 0;
    while ((got_q.size() < 8) && (guard < 300)) begin
      step();
      guard++;
      if ((armed == 0) && (xfer_cnt[0] == 4)) begin
        en[2] = 1'b1;
        armed = 1;
      end
    end
    n_checks++;
    if (got_q.size() < 8) begin n_errors++; $display("FAIL skip_timeout: got %0d transmits, expected 8", got_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_checks += 2;
        if (got_q[i].b !== b[i]) begin n_errors++; $display("FAIL skip_byte%0d: got %h expected %h", i, got_q[i].b, b[i]); end
        if (got_q[i].gid !== ((i < 4) ? 3'd0 : 3'd2)) begin n_errors++; $display("FAIL skip_gid%0d: got %0d expected %0d", i, got_q[i].gid, (i < 4) ? 0 : 2); end
      end
      n_checks++;
      if (got_q[4].cyc - got_q[3].cyc !== 12) begin n_errors++; $display("FAIL skip_gap: got %0d expected 12", got_q[4].cyc - got_q[3].cyc); end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] nb [4];
    int guard, seen_load;
    do_reset();
    for (int j = 0; j < NR; j++)
      for (int k = 0; k < 4; k++) src_q[j].push_back(8'($urandom_range(1, 255)));
    guard = 0;
    while (!((bus.grant_id == 3'd1) && (bus.dbg_state == ST_WAIT_LO) && (bus.dbg_byte_cnt == 2'd2)) && (guard < 300)) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 300) begin n_errors++; $display("FAIL midrst_reach: got no WAIT_LO of byte 2 within %0d cycles", guard); end
    #2 rst = 1'b1;
    #1;
    n_checks += 7;
    if (bus.transmit !== 1'b0)    begin n_errors++; $display("FAIL midrst_transmit: got %b expected 0", bus.transmit); end
    if (bus.tx_byte !== 8'h00)    begin n_errors++; $display("FAIL midrst_tx_byte: got %h expected 00", bus.tx_byte); end
    if (bus.req_ready !== '0)     begin n_errors++; $display("FAIL midrst_ready: got %b expected 0", bus.req_ready); end
    if (bus.grant_id !== 3'd0)    begin n_errors++; $display("FAIL midrst_grant: got %0d expected 0", bus.grant_id); end
    if (bus.word_active !== 1'b0) begin n_errors++; $display("FAIL midrst_active: got %b expected 0", bus.word_active); end
    if (bus.dbg_state !== ST_ARB) begin n_errors++; $display("FAIL midrst_state: got %0d expected %0d", bus.dbg_state, ST_ARB); end
    if (xfer_cnt[1] !== 3)        begin n_errors++; $display("FAIL midrst_xfers: got %0d expected 3", xfer_cnt[1]); end
    step();
    for (int j = 0; j < NR; j++) begin
      src_q[j].delete();
      xfer_cnt[j] = 0;
      for (int k = 0; k < 4; k++) src_q[j].push_back(8'($urandom_range(1, 255)));
    end
    for (int k = 0; k < 4; k++) nb[k] = src_q[0][k];
    step();
    rst = 1'b0;
    got_q.delete();
    seen_load = 0;
    guard = 0;
    while ((got_q.size() < 4) && (guard < 200)) begin
      step();
      guard++;
      if ((seen_load == 0) && (bus.dbg_state == ST_LOAD)) begin
        seen_load = 1;
        n_checks += 2;
        if (bus.dbg_byte_cnt !== 2'd0) begin n_errors++; $display("FAIL midrst_byte_cnt: got %0d expected 0", bus.dbg_byte_cnt); end
        if (bus.grant_id !== 3'd0) begin n_errors++; $display("FAIL midrst_new_grant: got %0d expected 0", bus.grant_id); end
      end
    end
    n_checks++;
    if (got_q.size() < 4) begin n_errors++; $display("FAIL midrst_timeout: got %0d transmits, expected 4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks += 3;
        if (got_q[i].b !== nb[i]) begin n_errors++; $display("FAIL midrst_byte%0d: got %h expected %h", i, got_q[i].b, nb[i]); end
        if (got_q[i].gid !== 3'd0) begin n_errors++; $display("FAIL midrst_gid%0d: got %0d expected 0", i, got_q[i].gid); end
        if (got_q[i].sync !== (i == 3)) begin n_errors++; $display("FAIL midrst_sync%0d: got %b expected %b", i, got_q[i].sync, (i == 3)); end
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol_cnt !== 0) begin n_errors++; $display("FAIL protocol: got %0d transmit violations expected 0", viol_cnt); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int j = 0; j < NR; j++) begin
      en[j]       = 1'b0;
      xfer_cnt[j] = 0;
    end
    test_reset();
    test_single_source();
    test_round_robin();
    test_pad();
    test_skip_idle();
    test_reset_mid_word();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/send_arbiter.md
SEND_ARBITER -- requirements
Module: send_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of byte sources (2..8).
REQ-002 Parameter PAD_TIMEOUT, default 255, idle cycles mid-word before a pad byte is inserted (1..255).
REQ-003 Parameter PAD_BYTE, default 8'h00, filler byte value.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-source byte available.
REQ-007 req_data  in  8*NUM_REQ  per-source byte; source i at bits [8i+7:8i].
REQ-008 req_ready  out  NUM_REQ  per-source accept; byte transfers when valid and ready are both high.
REQ-009 transmit  out  1  one-cycle start pulse to the serializer.
REQ-010 tx_byte  out  8  byte to serializer, valid while transmit is high.
REQ-011 is_transmitting  in  1  serializer busy flag.
REQ-012 grant_id  out  3  source owning the current word.
REQ-013 word_active  out  1  high while a 4-byte word is in progress.
REQ-014 pad_count  out  16  saturating count of pad bytes inserted.

Function
REQ-015 Traffic is arbitrated in atomic 4-byte words, keeping the serializer's every-4th-byte sync marker aligned to word boundaries.
REQ-016 States: ARB, LOAD, WAIT_HI, WAIT_LO.
REQ-017 ARB: if any req_valid is high, register the round-robin winner into grant_id, clear byte_cnt, go to LOAD; otherwise stay.
REQ-018 Round-robin: the winner is the first valid index after the previous winner, wrapping modulo NUM_REQ; after reset the search starts at index 0.
REQ-019 LOAD: req_ready[grant_id] is driven combinationally high, all other ready bits low; on valid, register tx_byte=data and transmit=1 for the next cycle, then go to WAIT_HI.
REQ-020 LOAD with req_valid[grant_id] low: increment stall_cnt; when stall_cnt reaches PAD_TIMEOUT, issue PAD_BYTE without asserting ready, increment pad_count, and go to WAIT_HI.
REQ-021 stall_cnt clears on every byte issued.
REQ-022 WAIT_HI: go to WAIT_LO when is_transmitting=1.
REQ-023 WAIT_LO: when is_transmitting=0, increment byte_cnt; if byte_cnt was 3, go to ARB, otherwise go to LOAD.
REQ-024 transmit is never high for two consecutive cycles and never high while is_transmitting=1.
REQ-025 Other sources' req_valid are ignored during a word, and a granted source may not be preempted mid-word.
REQ-026 Timing: valid seen in ARB at cycle T gives transfer at T+1, transmit at T+2; later bytes of the word follow every 11 cycles with back-to-back valid.
REQ-027 word_active is high from LOAD entry until return to ARB.
REQ-028 pad_count saturates at 16'hFFFF.

Reset
REQ-029 During reset: state=ARB, transmit=0, tx_byte=0, req_ready=0, grant_id=0, word_active=0, pad_count=0, byte_cnt=0, stall_cnt=0, round-robin pointer=NUM_REQ-1.
REQ-030 Reset mid-word abandons the word, and no req_ready pulse is issued for the interrupted byte.
REQ-031 send_arbiter and the serializer share the same rst, so both sync counters restart together.

Structure
REQ-032 A shared package holds the state encoding, the word length constant (4), and PAD_BYTE/PAD_TIMEOUT defaults.
REQ-033 The round-robin selection is one combinational sub-module, rr_pick (inputs: valid vector and last index; output: winner index and found flag).

Verification
REQ-034 Source 1 only, bytes A0..A3, with a serializer model -> four transmit pulses 11 cycles apart carrying A0,A1,A2,A3; grant_id=1; sync marker on A3.
REQ-035 All three sources continuously valid -> word order 0,1,2,0; no interleaving inside any word.
REQ-036 Source 0 drops valid after 2 bytes for 300 cycles -> PAD_BYTE sent after 255 stall cycles; pad_count=1; no ready pulse for the pad byte.
REQ-037 Source 2 valid only at the end of source 0's word -> source 2 is granted in the next ARB cycle, bypassing idle source 1.
REQ-038 rst asserted in WAIT_LO of byte 2 -> all outputs at reset values immediately; the next word starts with grant_id=0, byte_cnt=0.
REQ-039 Assertion checked throughout all tests -> transmit is never high while is_transmitting=1 or in consecutive cycles.
